// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU encodings, opcode/funct constants and control-word types for the
// ID/EX issue stage; the ALU itself decodes the same encodings.
package id_ex_alu_issue_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    TYPE_SHIFT = 2'b00,
    TYPE_SLT   = 2'b01,
    TYPE_ARITH = 2'b10,
    TYPE_LOGIC = 2'b11
  } op_type_e;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_e;

  typedef enum logic [1:0] {
    A_ZERO,
    A_RS,
    A_SHAMT
  } a_sel_e;

  typedef enum logic [2:0] {
    B_ZERO,
    B_RT,
    B_SEXT,
    B_ZEXT,
    B_LUI
  } b_sel_e;

  typedef struct packed {
    logic      signed_op;
    op_type_e  op_type;
    shift_op_e shift_op;
    logic      arith_sub;
    logic_op_e logic_op;
    logic      illegal;
  } alu_ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Unsigned add with every unused field zero; also the shape of an illegal op.
  function automatic alu_ctrl_t ctrl_default();
    alu_ctrl_t c;
    c.signed_op = 1'b0;
    c.op_type   = TYPE_ARITH;
    c.shift_op  = SHIFT_SLL;
    c.arith_sub = 1'b0;
    c.logic_op  = LOGIC_AND;
    c.illegal   = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/id_ex_alu_issue_if.sv
// Handshake and operand bundle between decode, the ID/EX issue stage and the ALU.
interface id_ex_alu_issue_if;
  import id_ex_alu_issue_pkg::*;

  logic            valid_in;
  logic            ready_out;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] rs_data_in;
  logic [XLEN-1:0] rt_data_in;
  logic            fwd_en_in;
  logic [4:0]      fwd_reg_in;
  logic [XLEN-1:0] fwd_data_in;
  logic            flush_in;
  logic            valid_out;
  logic            ready_in;
  logic [XLEN-1:0] a_out;
  logic [XLEN-1:0] b_out;
  logic            signed_operation_out;
  logic [1:0]      type_of_operation_out;
  logic [1:0]      shift_operation_out;
  logic            arithmetic_operation_out;
  logic [1:0]      logical_operation_out;
  logic            illegal_out;

  modport master (
    output valid_in, instr_in, rs_data_in, rt_data_in, fwd_en_in, fwd_reg_in,
           fwd_data_in, flush_in, ready_in,
    input  ready_out, valid_out, a_out, b_out, signed_operation_out,
           type_of_operation_out, shift_operation_out, arithmetic_operation_out,
           logical_operation_out, illegal_out
  );

  modport slave (
    input  valid_in, instr_in, rs_data_in, rt_data_in, fwd_en_in, fwd_reg_in,
           fwd_data_in, flush_in, ready_in,
    output ready_out, valid_out, a_out, b_out, signed_operation_out,
           type_of_operation_out, shift_operation_out, arithmetic_operation_out,
           logical_operation_out, illegal_out
  );
endinterface

// File: rtl/id_ex_alu_issue_alu_ctrl_decode.sv
// Pure combinational opcode/funct decode into ALU control fields plus the
// a/b operand source selects used by the issue stage.
module alu_ctrl_decode
  import id_ex_alu_issue_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       rot_imm_bit,
  input  logic       rot_var_bit,
  output alu_ctrl_t  ctrl,
  output a_sel_e     a_sel,
  output b_sel_e     b_sel
);

  always_comb begin
    ctrl  = ctrl_default();
    a_sel = A_ZERO;
    b_sel = B_ZERO;

    case (opcode)
      OP_RTYPE: begin
        a_sel = A_RS;
        b_sel = B_RT;
        case (funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
            ctrl.op_type = TYPE_SHIFT;
            if (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
              a_sel = A_SHAMT;
            // SRL/SRLV reuse a spare encoding bit to select rotate-right.
            if (funct == FN_SRL)
              ctrl.shift_op = rot_imm_bit ? SHIFT_ROR : SHIFT_SRL;
            else if (funct == FN_SRLV)
              ctrl.shift_op = rot_var_bit ? SHIFT_ROR : SHIFT_SRL;
            else if (funct == FN_SRA || funct == FN_SRAV)
              ctrl.shift_op = SHIFT_SRA;
            else
              ctrl.shift_op = SHIFT_SLL;
          end
          FN_ADD:  ctrl.signed_op = 1'b1;
          FN_ADDU: ;
          FN_SUB: begin
            ctrl.signed_op = 1'b1;
            ctrl.arith_sub = 1'b1;
          end
          FN_SUBU: ctrl.arith_sub = 1'b1;
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            ctrl.op_type  = TYPE_LOGIC;
            ctrl.logic_op = logic_op_e'(funct[1:0]);
          end
          FN_SLT, FN_SLTU: begin
            ctrl.op_type   = TYPE_SLT;
            ctrl.arith_sub = 1'b1;
            ctrl.signed_op = (funct == FN_SLT);
          end
          default: begin
            ctrl.illegal = 1'b1;
            a_sel        = A_ZERO;
            b_sel        = B_ZERO;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        a_sel          = A_RS;
        b_sel          = B_SEXT;
        ctrl.signed_op = (opcode == OP_ADDI);
      end
      OP_SLTI, OP_SLTIU: begin
        a_sel          = A_RS;
        b_sel          = B_SEXT;
        ctrl.op_type   = TYPE_SLT;
        ctrl.arith_sub = 1'b1;
        ctrl.signed_op = (opcode == OP_SLTI);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        a_sel         = A_RS;
        b_sel         = B_ZEXT;
        ctrl.op_type  = TYPE_LOGIC;
        ctrl.logic_op = logic_op_e'(opcode[1:0]);
      end
      OP_LUI: b_sel = B_LUI;
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: forwarding, operand build and a one-entry valid/ready
// register whose outputs feed the ALU inputs directly.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input logic             clk_in,
  input logic             rst_n_in,
  id_ex_alu_issue_if.slave bus
);

  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [4:0]        rs_idx;
  logic [4:0]        rt_idx;
  logic [15:0]       imm;
  logic [DATA_W-1:0] rs_eff;
  logic [DATA_W-1:0] rt_eff;
  logic [DATA_W-1:0] a_next;
  logic [DATA_W-1:0] b_next;
  alu_ctrl_t         ctrl_next;
  a_sel_e            a_sel;
  b_sel_e            b_sel;
  logic              load;

  logic              valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  alu_ctrl_t         ctrl_q;

  // Reset asserts immediately but releases two clocks after rst_n_in rises.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign rs_idx = bus.instr_in[25:21];
  assign rt_idx = bus.instr_in[20:16];
  assign imm    = bus.instr_in[15:0];

  alu_ctrl_decode u_decode (
    .opcode      (bus.instr_in[31:26]),
    .funct       (bus.instr_in[5:0]),
    .rot_imm_bit (bus.instr_in[21]),
    .rot_var_bit (bus.instr_in[6]),
    .ctrl        (ctrl_next),
    .a_sel       (a_sel),
    .b_sel       (b_sel)
  );

  // Register 0 is hardwired zero, so it is never a forwarding target.
  always_comb begin
    rs_eff = bus.rs_data_in;
    rt_eff = bus.rt_data_in;
    if (bus.fwd_en_in && bus.fwd_reg_in == rs_idx && rs_idx != 5'd0)
      rs_eff = bus.fwd_data_in;
    if (bus.fwd_en_in && bus.fwd_reg_in == rt_idx && rt_idx != 5'd0)
      rt_eff = bus.fwd_data_in;
  end

  always_comb begin
    a_next = '0;
    b_next = '0;
    case (a_sel)
      A_RS:    a_next = rs_eff;
      A_SHAMT: a_next = DATA_W'(bus.instr_in[10:6]);
      default: a_next = '0;
    endcase
    case (b_sel)
      B_RT:    b_next = rt_eff;
      B_SEXT:  b_next = DATA_W'({{16{imm[15]}}, imm});
      B_ZEXT:  b_next = DATA_W'({16'h0000, imm});
      B_LUI:   b_next = DATA_W'({imm, 16'h0000});
      default: b_next = '0;
    endcase
  end

  assign bus.ready_out = !valid_q || bus.ready_in;
  assign load          = bus.valid_in && bus.ready_out;

  // Flush beats load; a drain without a new load only clears valid.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= RESET_VAL;
      b_q     <= RESET_VAL;
      ctrl_q  <= '0;
    end else if (bus.flush_in) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      a_q     <= a_next;
      b_q     <= b_next;
      ctrl_q  <= ctrl_next;
    end else if (bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.valid_out                = valid_q;
  assign bus.a_out                    = a_q;
  assign bus.b_out                    = b_q;
  assign bus.signed_operation_out     = ctrl_q.signed_op;
  assign bus.type_of_operation_out    = ctrl_q.op_type;
  assign bus.shift_operation_out      = ctrl_q.shift_op;
  assign bus.arithmetic_operation_out = ctrl_q.arith_sub;
  assign bus.logical_operation_out    = ctrl_q.logic_op;
  assign bus.illegal_out              = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Directed bench for the ID/EX issue stage with hand-computed expected ALU inputs.
module tb_id_ex_alu_issue;

  logic clk_in;
  logic rst_n_in;
  int   n_checks;
  int   n_fail;

  id_ex_alu_issue_if bus ();

  id_ex_alu_issue #(
    .DATA_W    (32),
    .RESET_VAL (32'h0)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectAlu(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] typ, input logic [1:0] sh, input logic sub,
                           input logic [1:0] lg, input logic sgn, input logic ill,
                           input logic vld);
    checkOutput({tag, ".valid"},   32'(bus.valid_out), 32'(vld));
    checkOutput({tag, ".a"},       bus.a_out, a);
    checkOutput({tag, ".b"},       bus.b_out, b);
    checkOutput({tag, ".type"},    32'(bus.type_of_operation_out), 32'(typ));
    checkOutput({tag, ".shift"},   32'(bus.shift_operation_out), 32'(sh));
    checkOutput({tag, ".sub"},     32'(bus.arithmetic_operation_out), 32'(sub));
    checkOutput({tag, ".logic"},   32'(bus.logical_operation_out), 32'(lg));
    checkOutput({tag, ".signed"},  32'(bus.signed_operation_out), 32'(sgn));
    checkOutput({tag, ".illegal"}, 32'(bus.illegal_out), 32'(ill));
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] rs,
                               input logic [31:0] rt, input logic vld, input logic rdy);
    bus.instr_in    = instr;
    bus.rs_data_in  = rs;
    bus.rt_data_in  = rt;
    bus.valid_in    = vld;
    bus.ready_in    = rdy;
    bus.fwd_en_in   = 1'b0;
    bus.fwd_reg_in  = 5'd0;
    bus.fwd_data_in = 32'h0;
    bus.flush_in    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n_in = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (2) step();
    expectAlu("reset", 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.ready", 32'(bus.ready_out), 32'h1);
    rst_n_in = 1'b1;
    repeat (3) step();

    applyStimulus(32'h00A73020, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b1);
    checkOutput("add.pre_valid", 32'(bus.valid_out), 32'h0);
    step();
    expectAlu("add", 32'h7FFFFFFF, 32'h1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(rtype(0, 1, 2, 4, 6'h00), 32'h55, 32'h1, 1'b1, 1'b1);
    step();
    expectAlu("sll", 32'h4, 32'h1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(1, 1, 2, 4, 6'h02), 32'h55, 32'h80000001, 1'b1, 1'b1);
    step();
    expectAlu("rotr", 32'h4, 32'h80000001, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(9, 1, 2, 1, 6'h06), 32'h13, 32'hF0, 1'b1, 1'b1);
    step();
    expectAlu("rotrv", 32'h13, 32'hF0, 2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(9, 1, 2, 0, 6'h07), 32'h13, 32'hF0, 1'b1, 1'b1);
    step();
    expectAlu("srav", 32'h13, 32'hF0, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h22), 32'd10, 32'd3, 1'b1, 1'b1);
    step();
    expectAlu("sub", 32'd10, 32'd3, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h2B), 32'd10, 32'd3, 1'b1, 1'b1);
    step();
    expectAlu("sltu", 32'd10, 32'd3, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h27), 32'hF0F0, 32'h0FF0, 1'b1, 1'b1);
    step();
    expectAlu("nor", 32'hF0F0, 32'h0FF0, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);

    applyStimulus(itype(6'h0A, 2, 3, 16'hFFFF), 32'h5, 32'h9, 1'b1, 1'b1);
    step();
    expectAlu("slti", 32'h5, 32'hFFFFFFFF, 2'b01, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(itype(6'h0F, 0, 4, 16'h1234), 32'h99, 32'h9, 1'b1, 1'b1);
    step();
    expectAlu("lui", 32'h0, 32'h12340000, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(itype(6'h0D, 2, 3, 16'h8001), 32'h7, 32'h9, 1'b1, 1'b1);
    step();
    expectAlu("ori", 32'h7, 32'h00008001, 2'b11, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);

    applyStimulus(itype(6'h08, 2, 3, 16'h8000), 32'h7, 32'h9, 1'b1, 1'b1);
    step();
    expectAlu("addi", 32'h7, 32'hFFFF8000, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(itype(6'h3F, 2, 3, 16'h1234), 32'h7, 32'h8, 1'b1, 1'b1);
    step();
    expectAlu("ill_op", 32'h0, 32'h0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h01), 32'h7, 32'h8, 1'b1, 1'b1);
    step();
    expectAlu("ill_fn", 32'h0, 32'h0, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);

    applyStimulus(rtype(3, 4, 5, 0, 6'h20), 32'h0, 32'h5, 1'b1, 1'b1);
    bus.fwd_en_in = 1'b1; bus.fwd_reg_in = 5'd3; bus.fwd_data_in = 32'hDEADBEEF;
    step();
    expectAlu("fwd_rs", 32'hDEADBEEF, 32'h5, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(rtype(3, 4, 5, 0, 6'h20), 32'h0, 32'h5, 1'b1, 1'b1);
    bus.fwd_en_in = 1'b1; bus.fwd_reg_in = 5'd4; bus.fwd_data_in = 32'hDEADBEEF;
    step();
    checkOutput("fwd_rt.a", bus.a_out, 32'h0);
    checkOutput("fwd_rt.b", bus.b_out, 32'hDEADBEEF);

    applyStimulus(rtype(0, 4, 5, 0, 6'h20), 32'h11, 32'h5, 1'b1, 1'b1);
    bus.fwd_en_in = 1'b1; bus.fwd_reg_in = 5'd0; bus.fwd_data_in = 32'hDEADBEEF;
    step();
    checkOutput("fwd_r0.a", bus.a_out, 32'h11);

    applyStimulus(rtype(3, 4, 5, 0, 6'h20), 32'h22, 32'h5, 1'b1, 1'b1);
    bus.fwd_reg_in = 5'd3; bus.fwd_data_in = 32'hDEADBEEF;
    step();
    checkOutput("fwd_off.a", bus.a_out, 32'h22);

    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    checkOutput("drain.valid", 32'(bus.valid_out), 32'h0);
    checkOutput("drain.a", bus.a_out, 32'h22);

    applyStimulus(rtype(2, 3, 4, 0, 6'h20), 32'hA, 32'hB, 1'b1, 1'b0);
    step();
    checkOutput("bp_load.a", bus.a_out, 32'hA);
    applyStimulus(rtype(2, 3, 4, 0, 6'h22), 32'hC, 32'hD, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp.ready", 32'(bus.ready_out), 32'h0);
      step();
      expectAlu("bp_hold", 32'hA, 32'hB, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    end
    bus.ready_in = 1'b1;
    #1;
    checkOutput("bp_rel.ready", 32'(bus.ready_out), 32'h1);
    step();
    expectAlu("bp_next", 32'hC, 32'hD, 2'b10, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h20), 32'h77, 32'h1, 1'b1, 1'b1);
    bus.flush_in = 1'b1;
    step();
    checkOutput("flush.valid", 32'(bus.valid_out), 32'h0);
    checkOutput("flush.a", bus.a_out, 32'hC);

    applyStimulus(rtype(2, 3, 4, 0, 6'h21), 32'h33, 32'h44, 1'b1, 1'b1);
    step();
    expectAlu("addu", 32'h33, 32'h44, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    applyStimulus(rtype(2, 3, 4, 0, 6'h2A), 32'h55, 32'h66, 1'b1, 1'b1);
    step();
    checkOutput("slt.type", 32'(bus.type_of_operation_out), 32'h1);
    #2;
    rst_n_in = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    expectAlu("rst_mid", 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step();
    rst_n_in = 1'b1;
    repeat (3) step();

    applyStimulus(rtype(2, 3, 4, 0, 6'h20), 32'h1, 32'h2, 1'b1, 1'b1);
    step();
    expectAlu("post_rst", 32'h1, 32'h2, 2'b10, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
